// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter, 8 data bits, one parity bit, one stop bit
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tx_en,
  input  logic [7:0]                    data_in,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]     DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic            PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [15:0]     baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity;
  logic            push;
  logic            pop;
  logic            have_data;
  logic            baud_done;

  // Ready comes from the registered count only, so a full FIFO refuses a push
  // even in the cycle that pops.
  assign wr_ready  = (fifo_count < DEPTH_CNT);
  assign push      = wr_valid && wr_ready;
  assign have_data = (fifo_count != '0);
  assign baud_done = (baud_cnt == BAUD_LAST);

  // A byte leaves the FIFO when a frame starts from IDLE or chains from the
  // last cycle of STOP; both paths are gated by tx_en.
  assign pop = tx_en && have_data &&
               ((state == S_IDLE) || ((state == S_STOP) && baud_done));

  // Byte storage; contents are don't-care whenever the count says empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count separates full from empty.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame sequencer; tx is loaded with the next bit on the same edge that
  // ends the current one so every boundary is a single clean transition.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          if (pop) begin
            shift   <= mem[rd_ptr];
            parity  <= 1'b0;
            bit_cnt <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= S_START;
          end
        end

        S_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            parity   <= parity ^ shift[0];
            shift    <= {1'b0, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              tx    <= parity ^ shift[0] ^ PAR_INV;
              state <= S_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift   <= mem[rd_ptr];
              parity  <= 1'b0;
              bit_cnt <= '0;
              tx      <= 1'b0;
              state   <= S_START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        default: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard bench for uart_tx_buffered
module tb_uart_tx_buffered;

  logic       clock;
  logic       reset;
  logic       tx_en;
  logic [7:0] data_in;
  logic       wr_valid;

  logic       wr_ready_e, tx_e, busy_e;
  logic [2:0] count_e;
  logic       wr_ready_o, tx_o, busy_o;
  logic [2:0] count_o;

  int checks;
  int errors;

  logic [7:0] exp_q[$];

  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut_e (
    .clock(clock), .reset(reset), .tx_en(tx_en), .data_in(data_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready_e), .tx(tx_e), .busy(busy_e),
    .fifo_count(count_e)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_ODD(1)) dut_o (
    .clock(clock), .reset(reset), .tx_en(tx_en), .data_in(data_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready_o), .tx(tx_o), .busy(busy_o),
    .fifo_count(count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line waveform of one even-parity frame, one sample per cycle, oldest first
  function automatic logic [43:0] wave(input logic [7:0] b);
    logic [10:0] f;
    logic [43:0] w;
    f = {1'b1, ^b, b, 1'b0};
    for (int i = 0; i < 11; i++) w[i*4 +: 4] = {4{f[i]}};
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    wr_valid = 1'b1;
    data_in  = b;
    if (accepted) exp_q.push_back(b);
    tick();
  endtask

  task automatic wait_busy(input logic level, input int bound, input string tag);
    int n;
    n = 0;
    while (busy_e !== level && n < bound) begin
      @(negedge clock);
      n++;
    end
    check(tag, 64'(busy_e), 64'(level));
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (busy_e === 1'b1 && n < 1000) begin
      n++;
      @(negedge clock);
    end
  endtask

  // Frame monitor on the even-parity DUT: captures 44 samples from a start bit
  initial begin
    logic [43:0] mon_wave;
    logic [7:0]  exp_b;
    int          mon_idx;
    bit          mon_active;
    mon_wave   = '0;
    mon_idx    = 0;
    mon_active = 1'b0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        mon_active = 1'b0;
        mon_idx    = 0;
      end else if (mon_active || tx_e === 1'b0) begin
        mon_active        = 1'b1;
        mon_wave[mon_idx] = tx_e;
        mon_idx++;
        if (mon_idx == 44) begin
          mon_active = 1'b0;
          mon_idx    = 0;
          check("frame_pending", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check($sformatf("frame_%02h", exp_b), 64'(mon_wave), 64'(wave(exp_b)));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int zeros;
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    tx_en    = 1'b1;
    wr_valid = 1'b1;
    data_in  = 8'h99;

    // Reset with a write pending
    repeat (3) tick();
    @(negedge clock);
    check("rst_tx", 64'(tx_e), 64'(1));
    check("rst_wr_ready", 64'(wr_ready_e), 64'(1));
    check("rst_count", 64'(count_e), 64'(0));
    check("rst_busy", 64'(busy_e), 64'(0));
    reset    = 1'b1;
    wr_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_no_byte", 64'(count_e), 64'(0));
    check("rst_idle_tx", 64'(tx_e), 64'(1));

    // Single byte, latency and busy width
    push_byte(8'hA5, 1'b1);
    wr_valid = 1'b0;
    @(negedge clock);
    check("lat_count_after_push", 64'(count_e), 64'(1));
    check("lat_busy_before_pop", 64'(busy_e), 64'(0));
    @(negedge clock);
    check("lat_busy_after_pop", 64'(busy_e), 64'(1));
    check("lat_tx_start", 64'(tx_e), 64'(0));
    check("lat_count_after_pop", 64'(count_e), 64'(0));
    measure_busy(n);
    check("a5_busy_cycles", 64'(n), 64'(44));

    // Parity polarity on 0x07
    push_byte(8'h07, 1'b1);
    wr_valid = 1'b0;
    repeat (2) @(negedge clock);
    repeat (38) @(negedge clock);
    check("parity_even", 64'(tx_e), 64'(1));
    check("parity_odd", 64'(tx_o), 64'(0));
    wait_busy(1'b0, 100, "parity_frame_end");

    // FIFO full and back-to-back frames
    tx_en = 1'b0;
    for (int i = 1; i <= 5; i++) push_byte(8'(i), i <= 4);
    wr_valid = 1'b0;
    @(negedge clock);
    check("full_wr_ready", 64'(wr_ready_e), 64'(0));
    check("full_count", 64'(count_e), 64'(4));
    check("full_busy", 64'(busy_e), 64'(0));
    tx_en = 1'b1;
    wait_busy(1'b1, 10, "b2b_start");
    measure_busy(n);
    check("b2b_busy_cycles", 64'(n), 64'(176));
    check("b2b_count_end", 64'(count_e), 64'(0));

    // tx_en dropped mid-frame, with a simultaneous push and pop
    push_byte(8'h55, 1'b1);
    push_byte(8'hAA, 1'b1);
    wr_valid = 1'b0;
    @(negedge clock);
    check("pushpop_count", 64'(count_e), 64'(1));
    check("pushpop_busy", 64'(busy_e), 64'(1));
    repeat (15) @(negedge clock);
    tx_en = 1'b0;
    wait_busy(1'b0, 100, "drop_frame_end");
    repeat (8) @(negedge clock);
    check("drop_idle_tx", 64'(tx_e), 64'(1));
    check("drop_idle_busy", 64'(busy_e), 64'(0));
    check("drop_count", 64'(count_e), 64'(1));
    tx_en = 1'b1;
    wait_busy(1'b1, 10, "resume_start");
    wait_busy(1'b0, 100, "resume_end");
    check("resume_count", 64'(count_e), 64'(0));

    // Reset during the parity bit with two bytes queued
    tx_en = 1'b0;
    push_byte(8'h3C, 1'b1);
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    wr_valid = 1'b0;
    tx_en    = 1'b1;
    tick();
    tick();
    repeat (37) tick();
    @(negedge clock);
    check("midrst_pre_count", 64'(count_e), 64'(2));
    check("midrst_pre_busy", 64'(busy_e), 64'(1));
    reset = 1'b0;
    exp_q.delete();
    tick();
    @(negedge clock);
    check("midrst_tx", 64'(tx_e), 64'(1));
    check("midrst_busy", 64'(busy_e), 64'(0));
    check("midrst_count", 64'(count_e), 64'(0));
    check("midrst_wr_ready", 64'(wr_ready_e), 64'(1));
    reset = 1'b1;
    zeros = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (tx_e !== 1'b1) zeros++;
    end
    check("midrst_no_frames", 64'(zeros), 64'(0));

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter: accepts bytes over a valid/ready write port into a small FIFO and serialises each as start, 8 data bits LSB first, one parity bit, one stop bit. It is the transmit-side counterpart of the UART receiver. Its frame format (parity bit, then one stop bit) is exactly what the receiver checks for parity and stop errors. It sits between the host-side byte producer and the `tx` line of the UART physical layer.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit period; legal range 2–65535.
- `FIFO_DEPTH`, 4: byte slots; power of two, at least 2.
- `PARITY_ODD`, 0: 0 selects even parity; 1 selects odd parity.
- `clock`  in  1  the single clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `tx_en`  in  1  permits starting a new frame.
- `data_in`  in  8  byte to enqueue.
- `wr_valid`  in  1  `data_in` is valid this cycle.
- `wr_ready`  out  1  FIFO can accept a byte; high when count < `FIFO_DEPTH`.
- `tx`  out  1  serial line, registered, idles high.
- `busy`  out  1  a frame is in progress (state is not IDLE).
- `fifo_count`  out  clog2(`FIFO_DEPTH`)+1  bytes currently queued, excluding the byte being sent.

## Operation
- **Write port**
  - A byte is accepted on a rising edge when `wr_valid` and `wr_ready` are both high.
  - It is written at the write pointer; the write pointer and count increment.
  - Writes while full are ignored, and nothing else changes.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. A bit counter (0..7) and a baud counter (0..`CLKS_PER_BIT`-1) are used.
- **IDLE**
  - `tx` = 1.
  - If `tx_en` = 1 and count > 0: pop the head byte into the shift register, clear the parity accumulator, and go to START.
- **START:** `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - `tx` = shift[0] for `CLKS_PER_BIT` cycles per bit.
  - At the end of each bit: XOR the bit into parity, shift right, and increment the bit counter.
  - After bit 7, go to PARITY.
- **PARITY**
  - `tx` = parity XOR `PARITY_ODD` for `CLKS_PER_BIT` cycles.
  - Even parity: the 8 data bits plus the parity bit contain an even number of ones.
- **STOP**
  - `tx` = 1 for `CLKS_PER_BIT` cycles.
  - At the end: if `tx_en` = 1 and count > 0, pop the next byte and go straight to START (no idle gap). Otherwise go to IDLE.
- **Frame length:** exactly 11×`CLKS_PER_BIT` cycles.
- **`tx_en` low mid-frame:** the current frame completes unchanged; no new frame starts until `tx_en` returns high.
- **Simultaneous push and pop**
  - Both take effect; the count is unchanged.
  - `wr_ready` is derived from the registered count, so a full FIFO refuses a push even in a cycle that pops.
- **Pointers:** they wrap modulo `FIFO_DEPTH`; the count distinguishes full from empty.

## Timing
- **Reset** (`reset` = 0 at an edge):
  - state = IDLE; `tx` = 1; `busy` = 0; `fifo_count` = 0; `wr_ready` = 1.
  - Pointers and counters are 0; FIFO contents are discarded.
- **Reset mid-frame:** the frame is aborted. `tx` is 1 from the next cycle; queued bytes are lost.
- **Latency:**
  - Push accepted at edge N makes `fifo_count` = 1 after N.
  - If IDLE with `tx_en` = 1, the pop happens at edge N+1, and `tx` = 0 and `busy` = 1 after N+1.
- **`fifo_count`:** decrements at the pop edge.
- **`busy`:** falls at the edge that leaves STOP for IDLE, i.e. 11×`CLKS_PER_BIT` cycles after it rose. It stays high across back-to-back frames.
- **Bit boundaries:** every bit boundary is a single-cycle transition on `tx`. The line must hold no glitches and no extra cycles.

## Test plan
- **Reset values:** hold `reset` = 0 for 3 cycles with `wr_valid` = 1 → `tx` = 1, `wr_ready` = 1, `fifo_count` = 0, `busy` = 0, and no byte is queued.
- **Single byte, even parity** (`CLKS_PER_BIT` = 4, `tx_en` = 1): push 0xA5 → starting the cycle after the pop, `tx` is 0,1,0,1,0,0,1,0,1,0,1, each bit held for 4 cycles. `busy` is high for exactly 44 cycles.
- **Parity polarity:** push 0x07 → parity bit is 1 with `PARITY_ODD` = 0, and 0 with `PARITY_ODD` = 1.
- **Back-to-back and FIFO full:**
  - Push 5 bytes 0x01–0x05 on consecutive cycles with `tx_en` = 0 → 4 are accepted, `wr_ready` = 0, `fifo_count` = 4, and the 5th byte is dropped.
  - Then raise `tx_en` → 4 contiguous frames totalling 176 cycles with no idle cycle between them, in order 0x01–0x04, and `fifo_count` ends at 0.
- **`tx_en` dropped mid-frame:** queue 0x55 and 0xAA, then drop `tx_en` during the DATA bits of frame 1 → frame 1 completes, `tx` then idles high, and `fifo_count` = 1. Re-raising `tx_en` sends 0xAA.
- **Reset mid-frame:** assert `reset` during PARITY with 2 bytes queued → after the edge, `tx` = 1, `busy` = 0, `fifo_count` = 0, and no further frames are sent.
